// File: rtl/cv_pkg.sv
// Shared types and sizing helpers for the convolution pipeline (window generator and
// downstream kernel stages).
package cv_pkg;

  // Window element r*KernelWidth+c holds row r (0 = oldest line) and column c
  // (0 = leftmost); element KernelArea-1 is therefore the newest pixel.
  localparam bit WindowOldestRowFirst = 1'b1;

  localparam int unsigned DefKernelWidth = 3;
  localparam int unsigned DefWidthIn     = 1;

  function automatic int unsigned kernel_area(input int unsigned kernel_width);
    return kernel_width * kernel_width;
  endfunction

  // Accumulator width needed to sum a full window without overflow.
  function automatic int unsigned acc_width(input int unsigned width_in,
                                            input int unsigned kernel_width);
    return width_in + $clog2(kernel_area(kernel_width));
  endfunction

  // Default-sized window; users with other parameters declare the same shape locally.
  typedef logic [kernel_area(DefKernelWidth)-1:0][DefWidthIn-1:0] window_t;

endpackage

// File: rtl/line_buffer.sv
// One image line of history: circular buffer addressed by the column counter.
// Reading returns the contents from before this edge's write (read-before-write).
module line_buffer #(
  parameter int unsigned Depth = 160,
  parameter int unsigned Width = 1,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem [Depth];

  assign rdata_o = mem[addr_i];

  // Contents are never reset; the window counters gate anything stale.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/window_gen.sv
// Streaming sliding-window generator: emits a KernelWidth x KernelWidth window for every
// pixel position where the kernel lies fully inside the frame.
module window_gen
  import cv_pkg::*;
#(
  parameter int unsigned KernelWidth = 3,
  parameter int unsigned WidthIn     = 1,
  parameter int unsigned LineWidth   = 160,
  parameter int unsigned FrameHeight = 120,
  localparam int unsigned KernelArea = kernel_area(KernelWidth)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 valid_i,
  output logic                                 ready_o,
  input  logic [WidthIn-1:0]                   data_i,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic [KernelArea-1:0][WidthIn-1:0]   window_o
);

  localparam int unsigned ColW = $clog2(LineWidth);
  localparam int unsigned RowW = $clog2(FrameHeight);
  localparam logic [ColW-1:0] ColLast  = ColW'(LineWidth - 1);
  localparam logic [RowW-1:0] RowLast  = RowW'(FrameHeight - 1);
  localparam logic [ColW-1:0] ColFirst = ColW'(KernelWidth - 1);
  localparam logic [RowW-1:0] RowFirst = RowW'(KernelWidth - 1);

  typedef logic [KernelArea-1:0][WidthIn-1:0] win_t;

  logic [ColW-1:0]    col_q, col_d;
  logic [RowW-1:0]    row_q, row_d;
  logic               valid_q, valid_d;
  win_t               win_q, win_d;
  logic               accept;
  logic               complete;
  logic [WidthIn-1:0] line_rd [KernelWidth-1];

  assign ready_o  = !valid_q || ready_i;
  assign accept   = valid_i && ready_o;
  assign complete = (row_q >= RowFirst) && (col_q >= ColFirst);
  assign valid_o  = valid_q;
  assign window_o = win_q;

  // Line k holds the pixel from k+1 lines ago; each accept pushes history one line deeper.
  for (genvar k = 0; k < KernelWidth - 1; k++) begin : g_line
    if (k == 0) begin : g_first
      line_buffer #(
        .Depth (LineWidth),
        .Width (WidthIn)
      ) u_line_buffer (
        .clk_i   (clk_i),
        .en_i    (accept),
        .addr_i  (col_q),
        .wdata_i (data_i),
        .rdata_o (line_rd[k])
      );
    end else begin : g_chain
      line_buffer #(
        .Depth (LineWidth),
        .Width (WidthIn)
      ) u_line_buffer (
        .clk_i   (clk_i),
        .en_i    (accept),
        .addr_i  (col_q),
        .wdata_i (line_rd[k-1]),
        .rdata_o (line_rd[k])
      );
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  // The shift register doubles as the output register: it only moves on accept, and
  // accept is impossible while a window is stalled.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < KernelWidth; r++) begin
        for (int c = 0; c < KernelWidth - 1; c++) begin
          win_d[r*KernelWidth + c] = win_q[r*KernelWidth + c + 1];
        end
      end
      for (int r = 0; r < KernelWidth - 1; r++) begin
        win_d[r*KernelWidth + KernelWidth - 1] = line_rd[KernelWidth - 2 - r];
      end
      win_d[KernelArea-1] = data_i;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (accept) begin
      valid_d = complete;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      win_q   <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      win_q   <= win_d;
    end
  end

endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen on an 8x8 frame of 8-bit pixels valued row*8+col.
module tb_window_gen;

  localparam int unsigned K  = 3;
  localparam int unsigned W  = 8;
  localparam int unsigned LW = 8;
  localparam int unsigned FH = 8;
  localparam int unsigned KA = K * K;

  typedef logic [KA-1:0][W-1:0] win_t;

  logic         clk;
  logic         rst_ni;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] data_i;
  logic         valid_o;
  logic         ready_i;
  win_t         window_o;

  int   n_cmp;
  int   n_fail;
  bit   rnd_ready;
  win_t got_q[$];
  win_t first_win;
  win_t last_win;

  window_gen #(
    .KernelWidth (K),
    .WidthIn     (W),
    .LineWidth   (LW),
    .FrameHeight (FH)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .window_o (window_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output transfer; it completes on the following rising edge.
  always @(negedge clk) begin
    if (rst_ni && valid_o && ready_i) got_q.push_back(window_o);
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) ready_i = 1'($urandom_range(1));
    end
  end

  // Window k of a frame: newest pixel at row 2+k/6, column 2+k%6.
  function automatic win_t model_win(input int k);
    win_t w;
    int   r;
    int   c;
    r = 2 + k / 6;
    c = 2 + k % 6;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w[i*3 + j] = 8'((r - 2 + i) * 8 + (c - 2 + j));
      end
    end
    return w;
  endfunction

  task automatic send_pixel(input logic [W-1:0] p, input bit bubble);
    int waited;
    if (bubble) begin
      valid_i = 1'b0;
      @(posedge clk);
      #1;
    end
    valid_i = 1'b1;
    data_i  = p;
    waited  = 0;
    @(negedge clk);
    while (!ready_o) begin
      waited++;
      if (waited > 500) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_pixel: ready_o got %0b want 1 within 500 cycles", ready_o);
        $fatal(1, "input handshake timeout");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    rnd_ready = 1'b0;
    ready_i   = 1'b1;
    n = 0;
    @(negedge clk);
    while (valid_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: valid_o got %0b want 0", valid_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b1;
    #3;
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %0b want 0", valid_o);
    end
    n_cmp++;
    if (window_o !== '0) begin
      n_fail++;
      $display("FAIL reset_window: got %h want 0", window_o);
    end
    n_cmp++;
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %0b want 1", ready_o);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    got_q.delete();
    ready_i = 1'b1;
    for (int p = 0; p < 18; p++) send_pixel(8'(p), 1'b0);
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_pre_first: valid_o got %0b want 0", valid_o);
    end
    send_pixel(8'd18, 1'b0);
    n_cmp++;
    if (valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_first_valid: got %0b want 1", valid_o);
    end
    n_cmp++;
    if (window_o !== first_win) begin
      n_fail++;
      $display("FAIL stream_first_window: got %h want %h", window_o, first_win);
    end
    for (int p = 19; p < 64; p++) send_pixel(8'(p), 1'b0);
    drain();
    n_cmp++;
    if (got_q.size() != 36) begin
      n_fail++;
      $display("FAIL stream_count: got %0d want 36", got_q.size());
    end
    for (int k = 0; k < 36 && k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== model_win(k)) begin
        n_fail++;
        $display("FAIL stream_win%0d: got %h want %h", k, got_q[k], model_win(k));
      end
    end
    if (got_q.size() == 36) begin
      n_cmp++;
      if (got_q[35] !== last_win) begin
        n_fail++;
        $display("FAIL stream_last: got %h want %h", got_q[35], last_win);
      end
    end
  endtask

  task automatic test_backpressure();
    got_q.delete();
    ready_i = 1'b1;
    for (int p = 0; p < 19; p++) send_pixel(8'(p), 1'b0);
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 8'd19;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (ready_o !== 1'b0 || valid_o !== 1'b1 || window_o !== first_win) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: ready_o/valid_o/window got %0b/%0b/%h want 0/1/%h",
                 i, ready_o, valid_o, window_o, first_win);
      end
      @(posedge clk);
      #1;
    end
    ready_i = 1'b1;
    for (int p = 19; p < 64; p++) send_pixel(8'(p), 1'b0);
    drain();
    n_cmp++;
    if (got_q.size() != 36) begin
      n_fail++;
      $display("FAIL hold_count: got %0d want 36", got_q.size());
    end
    for (int k = 0; k < 36 && k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== model_win(k)) begin
        n_fail++;
        $display("FAIL hold_win%0d: got %h want %h", k, got_q[k], model_win(k));
      end
    end
  endtask

  task automatic test_random();
    got_q.delete();
    rnd_ready = 1'b1;
    for (int p = 0; p < 64; p++) send_pixel(8'(p), 1'($urandom_range(1)));
    drain();
    n_cmp++;
    if (got_q.size() != 36) begin
      n_fail++;
      $display("FAIL random_count: got %0d want 36", got_q.size());
    end
    for (int k = 0; k < 36 && k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== model_win(k)) begin
        n_fail++;
        $display("FAIL random_win%0d: got %h want %h", k, got_q[k], model_win(k));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    ready_i = 1'b1;
    for (int p = 0; p <= 30; p++) send_pixel(8'(p), 1'b0);
    n_cmp++;
    if (valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre_valid: got %0b want 1", valid_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if (valid_o !== 1'b0 || window_o !== '0) begin
      n_fail++;
      $display("FAIL midrst_async: valid_o/window got %0b/%h want 0/0", valid_o, window_o);
    end
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    got_q.delete();
    for (int p = 0; p < 18; p++) send_pixel(8'(p), 1'b0);
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_stale: valid_o got %0b want 0", valid_o);
    end
    send_pixel(8'd18, 1'b0);
    n_cmp++;
    if (valid_o !== 1'b1 || window_o !== first_win) begin
      n_fail++;
      $display("FAIL midrst_first: valid_o/window got %0b/%h want 1/%h",
               valid_o, window_o, first_win);
    end
    for (int p = 19; p < 64; p++) send_pixel(8'(p), 1'b0);
    drain();
    n_cmp++;
    if (got_q.size() != 36) begin
      n_fail++;
      $display("FAIL midrst_count: got %0d want 36", got_q.size());
    end
  endtask

  task automatic test_back_to_back();
    got_q.delete();
    ready_i = 1'b1;
    for (int p = 0; p < 128; p++) send_pixel(8'(p % 64), 1'b0);
    drain();
    n_cmp++;
    if (got_q.size() != 72) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d want 72", got_q.size());
    end
    for (int k = 0; k < 72 && k < got_q.size(); k++) begin
      n_cmp++;
      if (got_q[k] !== model_win(k % 36)) begin
        n_fail++;
        $display("FAIL b2b_win%0d: got %h want %h", k, got_q[k], model_win(k % 36));
      end
    end
    if (got_q.size() > 36) begin
      n_cmp++;
      if (got_q[36] !== first_win) begin
        n_fail++;
        $display("FAIL b2b_frame2_first: got %h want %h", got_q[36], first_win);
      end
    end
  endtask

  initial begin
    byte unsigned first_ref [9];
    byte unsigned last_ref [9];
    first_ref = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    last_ref  = '{45, 46, 47, 53, 54, 55, 61, 62, 63};
    for (int i = 0; i < 9; i++) begin
      first_win[i] = first_ref[i];
      last_win[i]  = last_ref[i];
    end
    n_cmp     = 0;
    n_fail    = 0;
    rnd_ready = 1'b0;
    rst_ni    = 1'b1;
    valid_i   = 1'b0;
    ready_i   = 1'b1;
    data_i    = '0;

    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_reset_mid_frame();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
